// File: rtl/ren_conv_pkg.sv
// rtl/ren_conv_pkg.sv - shared FSM state type and width defaults for the conv/pool stage
package ren_conv_pkg;
  localparam int ACC_WIDTH_DEF       = 21;
  localparam int PIX_WIDTH_DEF       = 8;
  localparam int RSLT_ADDR_WIDTH_DEF = 6;
  localparam int PIX_MAX             = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/ren_conv_scale.sv
// rtl/ren_conv_scale.sv - accumulator right-shift and pixel range reduction
// REN_CONV_POOL_SAT_EN selects saturation to 255; default keeps the low pixel bits.
module ren_conv_scale
  import ren_conv_pkg::*;
#(
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int PIX_WIDTH = PIX_WIDTH_DEF
) (
  input  logic [ACC_WIDTH-1:0] acc,
  input  logic [3:0]           shift,
  output logic [PIX_WIDTH-1:0] pix,
  output logic                 ovf
);
  logic [ACC_WIDTH-1:0] scaled;

  assign scaled = acc >> shift;
  assign ovf    = scaled > ACC_WIDTH'(PIX_MAX);

`ifdef REN_CONV_POOL_SAT_EN
  assign pix = ovf ? PIX_WIDTH'(PIX_MAX) : scaled[PIX_WIDTH-1:0];
`else
  assign pix = scaled[PIX_WIDTH-1:0];
`endif
endmodule

// File: rtl/ren_conv_pool.sv
// rtl/ren_conv_pool.sv - scales accumulators, optional pairwise max-pool, writes result memory
// Optional saturation via REN_CONV_POOL_SAT_EN (implemented in ren_conv_scale).
module ren_conv_pool
  import ren_conv_pkg::*;
#(
  parameter int ACC_WIDTH       = ACC_WIDTH_DEF,
  parameter int RSLT_ADDR_WIDTH = RSLT_ADDR_WIDTH_DEF,
  parameter int PIX_WIDTH       = PIX_WIDTH_DEF
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       soft_reset,
  input  logic                       start,
  input  logic [3:0]                 shift,
  input  logic                       en_max_pool,
  input  logic [7:0]                 result_cols,
  input  logic                       in_valid,
  input  logic [ACC_WIDTH-1:0]       in_data,
  output logic                       in_ready,
  output logic                       rslt_we,
  output logic [RSLT_ADDR_WIDTH-1:0] rslt_addr,
  output logic [PIX_WIDTH-1:0]       rslt_data,
  output logic                       done,
  output logic                       overflow
);
  state_t               state, state_nxt;
  logic [PIX_WIDTH-1:0] pix, held, wr_val;
  logic                 ovf, accept, complete, last, pair_flag, run_start;
  logic [7:0]           wr_cnt;

  ren_conv_scale #(
    .ACC_WIDTH(ACC_WIDTH),
    .PIX_WIDTH(PIX_WIDTH)
  ) u_scale (
    .acc  (in_data),
    .shift(shift),
    .pix  (pix),
    .ovf  (ovf)
  );

  assign in_ready  = (state == ST_RUN);
  assign done      = (state == ST_DONE);
  assign accept    = in_valid & in_ready;
  // With pooling on, only the second sample of a pair produces a write.
  assign complete  = accept & (~en_max_pool | pair_flag);
  assign last      = complete && (wr_cnt == result_cols);
  assign wr_val    = (en_max_pool && (held > pix)) ? held : pix;
  assign run_start = (state == ST_IDLE) && start;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (last) state_nxt = ST_DONE;
      ST_DONE: if (!start) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (soft_reset) state_nxt = ST_IDLE;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= ST_IDLE;
      rslt_we   <= 1'b0;
      rslt_addr <= '0;
      rslt_data <= '0;
      overflow  <= 1'b0;
      pair_flag <= 1'b0;
      held      <= '0;
      wr_cnt    <= '0;
    end else if (soft_reset) begin
      state     <= ST_IDLE;
      rslt_we   <= 1'b0;
      rslt_addr <= '0;
      rslt_data <= '0;
      overflow  <= 1'b0;
      pair_flag <= 1'b0;
      held      <= '0;
      wr_cnt    <= '0;
    end else begin
      state   <= state_nxt;
      rslt_we <= complete;
      if (run_start) begin
        wr_cnt    <= '0;
        pair_flag <= 1'b0;
        rslt_addr <= '0;
        overflow  <= 1'b0;
      end else begin
        // Address reflects the current write; advance once it has been presented.
        if (rslt_we) rslt_addr <= rslt_addr + RSLT_ADDR_WIDTH'(1);
        if (accept) begin
          if (ovf) overflow <= 1'b1;
          pair_flag <= en_max_pool & ~pair_flag;
          if (!pair_flag) held <= pix;
        end
        if (complete) begin
          wr_cnt    <= wr_cnt + 8'd1;
          rslt_data <= wr_val;
        end
      end
    end
  end
endmodule

// File: tb/tb_ren_conv_pool.sv
// tb/tb_ren_conv_pool.sv - scoreboard bench for ren_conv_pool
module tb_ren_conv_pool;
  logic        clk = 1'b0;
  logic        rst;
  logic        soft_reset, start, en_max_pool, in_valid;
  logic [3:0]  shift;
  logic [7:0]  result_cols;
  logic [20:0] in_data;
  logic        in_ready, rslt_we, done, overflow;
  logic [5:0]  rslt_addr;
  logic [7:0]  rslt_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int addr;
    int data;
  } wr_t;
  wr_t         sbq[$];
  logic [20:0] stim[$];

`ifdef REN_CONV_POOL_SAT_EN
  localparam int OVF_PIX = 255;
`else
  localparam int OVF_PIX = 44;
`endif

  ren_conv_pool dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .soft_reset (soft_reset),
    .start      (start),
    .shift      (shift),
    .en_max_pool(en_max_pool),
    .result_cols(result_cols),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .rslt_we    (rslt_we),
    .rslt_addr  (rslt_addr),
    .rslt_data  (rslt_data),
    .done       (done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic push(input int a, input int d);
    wr_t e;
    e.addr = a;
    e.data = d;
    sbq.push_back(e);
  endtask

  // Monitor: every write strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && rslt_we) begin
      wr_t e;
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual=%0d@%0d required=none", rslt_data, rslt_addr);
      end else begin
        e = sbq.pop_front();
        if (rslt_addr !== 6'(e.addr) || rslt_data !== 8'(e.data)) begin
          errors++;
          $display("FAIL write actual=%0d@%0d required=%0d@%0d", rslt_data, rslt_addr, e.data, e.addr);
        end
      end
    end
  end

  task automatic feed();
    foreach (stim[i]) begin
      int t = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = stim[i];
      while (!in_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) begin
        chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (!done && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk(name, done, 1);
  endtask

  task automatic run(input int cols, input bit pool, input int sh, input string name);
    result_cols = 8'(cols);
    en_max_pool = pool;
    shift       = 4'(sh);
    @(negedge clk);
    start = 1'b1;
    feed();
    wait_done(name);
  endtask

  task automatic end_run();
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; soft_reset = 1'b0; start = 1'b0; en_max_pool = 1'b0;
    in_valid = 1'b0; shift = 4'd0; result_cols = 8'd0; in_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_we", rslt_we, 0);
    chk("rst_addr", rslt_addr, 0);
    chk("rst_data", rslt_data, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    rst = 1'b0;

    // No pooling, second sample overflows
    stim = {21'd10, 21'd300};
    push(0, 10); push(1, OVF_PIX);
    run(1, 0, 0, "t1_done");
    chk("t1_overflow", overflow, 1);
    @(negedge clk);
    chk("t1_in_ready_done", in_ready, 0);

    // start held high after done must not retrigger
    in_valid = 1'b1; in_data = 21'd5;
    repeat (10) @(negedge clk);
    chk("held_done", done, 1);
    chk("held_in_ready", in_ready, 0);
    in_valid = 1'b0;
    end_run();
    chk("idle_done", done, 0);
    push(0, 10); push(1, OVF_PIX);
    start = 1'b1;
    @(negedge clk);
    chk("rerun_ovf_cleared", overflow, 0);
    chk("rerun_in_ready", in_ready, 1);
    feed();
    wait_done("rerun_done");
    chk("rerun_overflow", overflow, 1);
    end_run();

    // Pairwise max pooling
    stim = {21'd5, 21'd9, 21'd12, 21'd7};
    push(0, 9); push(1, 12);
    run(1, 1, 0, "pool_done");
    chk("pool_overflow", overflow, 0);
    end_run();

    // Shift scaling
    stim = {21'h00A50};
    push(0, 165);
    run(0, 0, 4, "sh4_done");
    chk("sh4_overflow", overflow, 0);
    end_run();
    stim = {21'h1FFFFF};
    push(0, 255);
    run(0, 0, 12, "sh12_done");
    chk("sh12_overflow", overflow, 1);
    end_run();

    // Hard reset after 3 of 8 writes
    stim = {21'd1, 21'd2, 21'd3};
    push(0, 1); push(1, 2); push(2, 3);
    result_cols = 8'd7; en_max_pool = 1'b0; shift = 4'd0;
    @(negedge clk);
    start = 1'b1;
    feed();
    @(negedge clk);
    chk("mid_in_ready", in_ready, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_in_ready", in_ready, 0);
    chk("arst_we", rslt_we, 0);
    chk("arst_addr", rslt_addr, 0);
    chk("arst_data", rslt_data, 0);
    chk("arst_done", done, 0);
    chk("arst_overflow", overflow, 0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    stim = {21'd7, 21'd8};
    push(0, 7); push(1, 8);
    run(1, 0, 0, "post_rst_done");
    end_run();

    // Soft reset overrides start and in_valid
    stim = {21'd50};
    push(0, 50);
    result_cols = 8'd3; en_max_pool = 1'b0; shift = 4'd0;
    @(negedge clk);
    start = 1'b1;
    feed();
    @(negedge clk);
    soft_reset = 1'b1; in_valid = 1'b1; in_data = 21'd9;
    @(negedge clk);
    soft_reset = 1'b0; start = 1'b0; in_valid = 1'b0;
    chk("srst_in_ready", in_ready, 0);
    chk("srst_addr", rslt_addr, 0);
    chk("srst_data", rslt_data, 0);
    chk("srst_done", done, 0);
    @(negedge clk);
    chk("srst_we", rslt_we, 0);

    // 70 writes with address wrap
    stim.delete();
    for (int i = 0; i < 70; i++) begin
      stim.push_back(21'(i + 1));
      push(i % 64, i + 1);
    end
    run(69, 0, 0, "wrap_done");
    chk("wrap_overflow", overflow, 0);
    end_run();

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ren_conv_pool.md
REN_CONV_POOL -- requirements
Module: ren_conv_pool

Interface
REQ-001 SHALL have parameter ACC_WIDTH, default 21, convolution accumulator width.
REQ-002 SHALL have parameter RSLT_ADDR_WIDTH, default 6, result memory address width.
REQ-003 SHALL have parameter PIX_WIDTH, default 8, result pixel width.
REQ-004 SHALL have port wb_clk_i  input  1  the only clock; all logic on its rising edge.
REQ-005 SHALL have port wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port soft_reset  input  1  synchronous clear from control register bit 1.
REQ-007 SHALL have port start  input  1  level run request from control register bit 2.
REQ-008 SHALL have port shift  input  4  right-shift applied to each accumulator.
REQ-009 SHALL have port en_max_pool  input  1  pairwise max-pool enable.
REQ-010 SHALL have port result_cols  input  8  number of result writes minus one.
REQ-011 SHALL have port in_valid  input  1  accumulator valid from convolver.
REQ-012 SHALL have port in_data  input  ACC_WIDTH  unsigned accumulator.
REQ-013 SHALL have port in_ready  output  1  stage accepts in_data.
REQ-014 SHALL have port rslt_we  output  1  result memory write strobe.
REQ-015 SHALL have port rslt_addr  output  RSLT_ADDR_WIDTH  result memory word address.
REQ-016 SHALL have port rslt_data  output  PIX_WIDTH  result pixel.
REQ-017 SHALL have port done  output  1  run complete, status bit 0.
REQ-018 SHALL have port overflow  output  1  sticky: a shifted value exceeded 255.

Function
REQ-019 SHALL implement FSM IDLE -> RUN on start=1 in IDLE; RUN -> DONE after the last write; DONE -> IDLE when start=0.
REQ-020 SHALL clear write counter, pair flag, rslt_addr and overflow on the IDLE->RUN transition.
REQ-021 SHALL drive in_ready=1 only in RUN; a sample is accepted when in_valid&in_ready.
REQ-022 SHALL compute scaled = in_data >> shift (logical, full ACC_WIDTH) before pooling.
REQ-023 SHALL with en_max_pool=0 write every accepted sample; with en_max_pool=1 hold the first of each pair and write unsigned max of the pair on the second (tie: either, equal value).
REQ-024 SHALL assert rslt_we for exactly one cycle, the cycle after the completing sample is accepted (latency 1).
REQ-025 SHALL start rslt_addr at 0, increment after each write, and wrap modulo 2^RSLT_ADDR_WIDTH.
REQ-026 SHALL transition to DONE after write number result_cols+1 and deassert in_ready in the same cycle that write is issued.
REQ-027 SHALL hold done=1 throughout DONE; start held high after done SHALL NOT retrigger a run.
REQ-028 SHALL set overflow when any scaled value >255, held until next run start or reset.
REQ-029 SHALL on soft_reset=1 return to IDLE next edge, clear all state and outputs, overriding any simultaneous start or in_valid.

Reset
REQ-030 SHALL on wb_rst_i=1 immediately force IDLE, in_ready=0, rslt_we=0, rslt_addr=0, rslt_data=0, done=0, overflow=0, pair flag clear, including mid-run.

Configuration
REQ-031 SHALL with REN_CONV_POOL_SAT_EN defined saturate scaled values >255 to 255; without it SHALL output the low PIX_WIDTH bits (overflow flag still set in both cases).

Structure
REQ-032 SHALL take FSM state typedef and ACC_WIDTH/PIX_WIDTH/RSLT_ADDR_WIDTH defaults from shared package ren_conv_pkg.
REQ-033 SHALL place shift+saturate/truncate logic in one sub-module ren_conv_scale; pooling, counters and FSM stay in the top.

Verification
REQ-034 SHALL cover: pool off, shift 0, result_cols 1, inputs 10, 300 -> writes 10@0, 255@1 (SAT_EN) or 44@1 (no SAT_EN), overflow=1, done=1.
REQ-035 SHALL cover: pool on, shift 0, result_cols 1, inputs 5,9,12,7 -> writes 9@0, 12@1, done=1, overflow=0.
REQ-036 SHALL cover: shift 4, input 0x00A50 -> rslt_data 165; shift 12, input 0x1FFFFF -> 255 (SAT_EN), overflow=1.
REQ-037 SHALL cover: wb_rst_i pulsed after 3 of 8 writes -> all outputs 0 immediately; restart -> addresses resume from 0.
REQ-038 SHALL cover: start held high after done -> no further writes; start 0 then 1 -> second identical run with overflow cleared.
REQ-039 SHALL cover: result_cols 69, pool off -> 70 writes, address wraps 63->0, done after 70th write.
